// File: rtl/char_rom_arbiter_pkg.sv
// Shared widths, burst length and state encoding for the character ROM arbiter.
// Also provides the helper that maps a target to the first address of its row.
package char_rom_arbiter_pkg;

    localparam int CHAR_YX_W   = 8;
    localparam int CHAR_CODE_W = 7;
    localparam int BURST_LEN   = 16;
    localparam int BEAT_W      = $clog2(BURST_LEN);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // A burst always starts at x = 0 of the requested row.
    function automatic logic [CHAR_YX_W-1:0] row_start(input logic [CHAR_YX_W-1:0] yx);
        return {yx[CHAR_YX_W-1:BEAT_W], {BEAT_W{1'b0}}};
    endfunction

endpackage

// File: rtl/char_rom_arbiter.sv
// Two-port arbiter in front of a 16x16 character ROM: single reads or whole-row bursts,
// round-robin on contention, one beat per cycle, response two cycles after grant.
module char_rom_arbiter
    import char_rom_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [CHAR_YX_W-1:0]   yx0,
    input  logic [CHAR_YX_W-1:0]   yx1,
    input  logic                   line0,
    input  logic                   line1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic [CHAR_YX_W-1:0]   rom_char_yx,
    input  logic [CHAR_CODE_W-1:0] rom_char_code,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [CHAR_YX_W-1:0]   rsp_yx,
    output logic [CHAR_CODE_W-1:0] rsp_code,
    output logic                   rsp_last
);

    // Handshake: a requester holds req/yx/line stable until the cycle its gnt is
    // high; gnt is a combinational one-cycle accept, the address follows next cycle.

    arb_state_e          state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   next_beat;
    logic                rr_ptr;
    logic                grant_ok;
    logic                pick1;
    logic                any_gnt;
    logic                gnt_id;
    logic                gnt_line;
    logic [CHAR_YX_W-1:0] gnt_yx;
    logic                iss_valid;
    logic                iss_id;
    logic                iss_last;

    // rr_ptr = 1 means port 1 wins the next tie.
    always_comb begin
        grant_ok  = (state == ST_IDLE) || (beat_cnt == LAST_BEAT);
        pick1     = req1 && (!req0 || rr_ptr);
        gnt1      = !rst && grant_ok && pick1;
        gnt0      = !rst && grant_ok && req0 && !pick1;
        any_gnt   = gnt0 || gnt1;
        gnt_id    = gnt1;
        gnt_line  = gnt1 ? line1 : line0;
        gnt_yx    = gnt1 ? yx1 : yx0;
        next_beat = beat_cnt + BEAT_W'(1);
    end

    assign rsp_code = rom_char_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            rr_ptr      <= 1'b0;
            rom_char_yx <= '0;
            iss_valid   <= 1'b0;
            iss_id      <= 1'b0;
            iss_last    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_yx      <= '0;
            rsp_last    <= 1'b0;
        end else begin
            // Response stage lines up with ROM data, one cycle behind the address.
            rsp_valid <= iss_valid;
            rsp_id    <= iss_id;
            rsp_yx    <= rom_char_yx;
            rsp_last  <= iss_last;

            if (any_gnt) begin
                rr_ptr    <= ~gnt_id;
                iss_valid <= 1'b1;
                iss_id    <= gnt_id;
                beat_cnt  <= '0;
                if (gnt_line) begin
                    state       <= ST_BURST;
                    rom_char_yx <= row_start(gnt_yx);
                    iss_last    <= 1'b0;
                end else begin
                    state       <= ST_IDLE;
                    rom_char_yx <= gnt_yx;
                    iss_last    <= 1'b1;
                end
            end else if (state == ST_BURST && beat_cnt != LAST_BEAT) begin
                // Only the x nibble advances, so the row never wraps.
                beat_cnt    <= next_beat;
                rom_char_yx <= {rom_char_yx[CHAR_YX_W-1:BEAT_W], next_beat};
                iss_valid   <= 1'b1;
                iss_last    <= (next_beat == LAST_BEAT);
            end else begin
                state     <= ST_IDLE;
                beat_cnt  <= '0;
                iss_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter with a registered 16x16 character ROM attached;
// expected beats are queued at stimulus time and checked by an independent monitor.
module tb_char_rom_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [7:0] yx0, yx1;
    logic       line0, line1;
    logic       gnt0, gnt1;
    logic [7:0] rom_char_yx;
    logic [6:0] rom_char_code;
    logic       rsp_valid, rsp_id, rsp_last;
    logic [7:0] rsp_yx;
    logic [6:0] rsp_code;

    int checks = 0;
    int errors = 0;

    // {id, yx, code, last}
    logic [16:0] exp_q[$];

    char_rom_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .req1          (req1),
        .yx0           (yx0),
        .yx1           (yx1),
        .line0         (line0),
        .line1         (line1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rom_char_yx   (rom_char_yx),
        .rom_char_code (rom_char_code),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_yx        (rsp_yx),
        .rsp_code      (rsp_code),
        .rsp_last      (rsp_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- character ROM ----------------
    function automatic logic [6:0] rom_fn(input logic [7:0] a);
        if (a[7:4] == 4'h3)     return 7'd1;
        else if (a[7:4] == 4'hF) return 7'd95;
        else if (a == 8'h23)    return 7'd121;
        else                    return a[6:0] ^ 7'h2A;
    endfunction

    always @(posedge clk) rom_char_code <= rom_fn(rom_char_yx);

    // ---------------- helpers / driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic id, input logic [7:0] yx, input logic [6:0] code,
                             input logic last);
        exp_q.push_back({id, yx, code, last});
    endtask

    task automatic push_burst(input logic id, input logic [3:0] row, input logic [6:0] code,
                              input int nbeats);
        for (int x = 0; x < nbeats; x++)
            push_beat(id, {row, 4'(x)}, code, (x == 15));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1, want at most one");
            end
            if (rsp_valid) begin
                logic [16:0] got;
                logic [16:0] want;
                got = {rsp_id, rsp_yx, rsp_code, rsp_last};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d yx=%h code=%0d last=%0d, want no beat",
                             rsp_id, rsp_yx, rsp_code, rsp_last);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL rsp_beat: got id=%0d yx=%h code=%0d last=%0d, want id=%0d yx=%h code=%0d last=%0d",
                                 got[16], got[15:8], got[7:1], got[0],
                                 want[16], want[15:8], want[7:1], want[0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int found;
        rst = 1'b1;
        req0 = 0; req1 = 0; yx0 = '0; yx1 = '0; line0 = 0; line1 = 0;

        // Reset state, and no grant while in reset.
        repeat (2) step();
        req0 = 1'b1;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_rom_yx", rom_char_yx, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_id, rsp_yx, rsp_last}, 0);
        req0 = 1'b0;
        rst  = 1'b0;
        step();

        // Contention right after reset: port 0, then port 1, then port 0 again.
        push_beat(0, 8'h23, 7'd121, 1);
        push_beat(1, 8'h00, 7'd42, 1);
        push_beat(0, 8'h47, 7'd109, 1);
        req0 = 1; yx0 = 8'h23; req1 = 1; yx1 = 8'h00;
        #1;
        chk("cont_first_gnt0", gnt0, 1);
        chk("cont_first_gnt1", gnt1, 0);
        step();
        yx0 = 8'h47;
        #1;
        chk("cont_second_gnt1", gnt1, 1);
        chk("cont_second_gnt0", gnt0, 0);
        step();
        req1 = 0;
        #1;
        chk("cont_third_gnt0", gnt0, 1);
        step();
        req0 = 0;
        repeat (4) step();

        // Single read with its two-cycle latency.
        push_beat(0, 8'h23, 7'd121, 1);
        req0 = 1; yx0 = 8'h23; line0 = 0;
        #1;
        chk("single_gnt0", gnt0, 1);
        step();
        req0 = 0;
        #1;
        chk("single_addr", rom_char_yx, 8'h23);
        chk("single_no_rsp_yet", rsp_valid, 0);
        step();
        #1;
        chk("single_rsp_valid", rsp_valid, 1);
        repeat (3) step();

        // Row-3 burst from port 1, starting from a non-zero x.
        push_burst(1, 4'h3, 7'd1, 16);
        req1 = 1; yx1 = 8'h35; line1 = 1;
        #1;
        chk("burst_gnt1", gnt1, 1);
        step();
        req1 = 0; line1 = 0;
        #1;
        chk("burst_first_addr", rom_char_yx, 8'h30);
        repeat (20) step();

        // Row-F burst with a waiting single: grant lands at beat 15, no gap.
        push_burst(0, 4'hF, 7'd95, 16);
        push_beat(1, 8'h47, 7'd109, 1);
        req0 = 1; yx0 = 8'hF7; line0 = 1;
        #1;
        chk("b2b_gnt0", gnt0, 1);
        step();
        req0 = 0; line0 = 0;
        req1 = 1; yx1 = 8'h47; line1 = 0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (gnt1) begin
                found = i;
                break;
            end
            step();
        end
        chk("b2b_gnt_cycle", found, 16);
        chk("b2b_addr_at_gnt", rom_char_yx, 8'hFF);
        step();
        req1 = 0;
        #1;
        chk("b2b_next_addr", rom_char_yx, 8'h47);
        repeat (5) step();

        // Reset while a row-3 burst is at beat 6; beats 0..4 reach rsp before it.
        push_burst(0, 4'h3, 7'd1, 5);
        req0 = 1; yx0 = 8'h3A; line0 = 1;
        #1;
        chk("rstmid_gnt0", gnt0, 1);
        step();
        req0 = 0; line0 = 0;
        repeat (6) step();
        chk("rstmid_beat6_addr", rom_char_yx, 8'h36);
        rst = 1'b1;
        #1;
        chk("rstmid_rom_yx", rom_char_yx, 0);
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_rsp_fields", {rsp_id, rsp_yx, rsp_last}, 0);
        step();
        req0 = 1; line0 = 1;
        #1;
        chk("rstmid_gnt_blocked", gnt0, 0);
        req0 = 0; line0 = 0;
        rst = 1'b0;
        repeat (4) step();

        // Fresh request after the aborted burst.
        push_beat(1, 8'h23, 7'd121, 1);
        req1 = 1; yx1 = 8'h23; line1 = 0;
        #1;
        chk("fresh_gnt1", gnt1, 1);
        step();
        req1 = 0;
        #1;
        chk("fresh_addr", rom_char_yx, 8'h23);
        repeat (5) step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
